// File: rtl/control_fsm_if.sv
// control_fsm_if: control-unit bundle between the FSM (master) and memory/datapath (slave).
interface control_fsm_if #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6
);
    logic [WIDTH-1:0]         mem_rdata;
    logic                     mem_ack;
    logic [WIDTH-1:0]         psr;
    logic                     mem_req;
    logic                     mem_we;
    logic                     addr_sel;
    logic                     ir_we;
    logic [ALU_CONT_BITS-1:0] alu_cont;
    logic [1:0]               b_sel;
    logic [3:0]               ra_addr;
    logic [3:0]               rb_addr;
    logic                     rf_we;
    logic [1:0]               wb_sel;
    logic                     psr_we;
    logic                     pc_en;
    logic [1:0]               pc_src;

    modport master (
        input  mem_rdata, mem_ack, psr,
        output mem_req, mem_we, addr_sel, ir_we, alu_cont, b_sel, ra_addr, rb_addr,
               rf_we, wb_sel, psr_we, pc_en, pc_src
    );

    modport slave (
        output mem_rdata, mem_ack, psr,
        input  mem_req, mem_we, addr_sel, ir_we, alu_cont, b_sel, ra_addr, rb_addr,
               rf_we, wb_sel, psr_we, pc_en, pc_src
    );
endinterface

// File: rtl/control_fsm.sv
// control_fsm: multicycle fetch/decode/exec/mem/wb control unit for the 16-bit datapath.
module control_fsm #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6
) (
    input  logic          clk,
    input  logic          reset,
    control_fsm_if.master bus
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ir_q;
    logic             run_q;
    logic [3:0]       op, rd, ext, code;
    logic             rtype, imm, lui, lsh, lshi, alu_op, cmp;
    logic             load, stor, jal, jcond, bcond, taken, ack;
    logic             c, l, f, z, n;
    logic [15:0]      conds;
    logic             unused_psr;

    assign op    = ir_q[15:12];
    assign rd    = ir_q[11:8];
    assign ext   = ir_q[7:4];
    assign code  = (op == 4'h0) ? ext : op;
    assign rtype = (op == 4'h0) && (ext inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD});
    assign imm   = op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h9, 4'hB, 4'hD};
    assign lui   = op == 4'hF;
    assign lsh   = (op == 4'h8) && (ext == 4'h4);
    assign lshi  = (op == 4'h8) && (ext[3:1] == 3'b000);
    assign alu_op = rtype || imm || lui || lsh || lshi;
    assign cmp   = (rtype || imm) && (code == 4'hB);
    assign load  = (op == 4'h4) && (ext == 4'h0);
    assign stor  = (op == 4'h4) && (ext == 4'h4);
    assign jal   = (op == 4'h4) && (ext == 4'h8);
    assign jcond = (op == 4'h4) && (ext == 4'hC);
    assign bcond = op == 4'hC;

    assign c = bus.psr[0];
    assign l = bus.psr[2];
    assign f = bus.psr[5];
    assign z = bus.psr[6];
    assign n = bus.psr[7];
    assign unused_psr = ^{bus.psr[WIDTH-1:8], bus.psr[4:3], bus.psr[1]};
    // Indexed by the 4-bit condition code: bit 15 = never, bit 14 = always.
    assign conds = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !f, f,
                    !n, n, !l, l, !c, c, !z, z};
    assign taken = conds[rd];
    // run_q holds outputs low for the cycle after a reset edge, so acks there are ignored.
    assign ack   = bus.mem_ack && run_q;

    always_comb begin
        state_d      = state_q;
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.addr_sel = 1'b0;
        bus.ir_we    = 1'b0;
        bus.alu_cont = '0;
        bus.b_sel    = 2'd0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 2'd0;
        bus.psr_we   = 1'b0;
        bus.pc_en    = 1'b0;
        bus.pc_src   = 2'd0;
        bus.ra_addr  = rd;
        bus.rb_addr  = ir_q[3:0];
        case (state_q)
            FETCH: begin
                bus.mem_req = run_q;
                bus.ir_we   = ack;
                state_d     = ack ? DECODE : FETCH;
            end
            DECODE: state_d = EXEC;
            EXEC: begin
                state_d      = (load || stor) ? MEM : FETCH;
                bus.pc_en    = !(load || stor);
                bus.alu_cont = lui ? ALU_CONT_BITS'(6'h3F) :
                               (lsh || lshi) ? ALU_CONT_BITS'(6'h07) :
                               jal ? ALU_CONT_BITS'(6'h0D) :
                               alu_op ? ALU_CONT_BITS'(code) : '0;
                bus.b_sel    = (lui || (imm && op inside {4'h1, 4'h2, 4'h3})) ? 2'd2 :
                               (imm || lshi) ? 2'd1 : 2'd0;
                bus.rf_we    = (alu_op && !cmp) || jal;
                bus.psr_we   = (rtype || imm) && (code inside {4'h5, 4'h9, 4'hB});
                bus.wb_sel   = jal ? 2'd2 : 2'd0;
                bus.pc_src   = (jal || (jcond && taken)) ? 2'd1 :
                               (bcond && taken) ? 2'd2 : 2'd0;
            end
            MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = stor;
                bus.pc_en    = ack && stor;
                state_d      = !ack ? MEM : load ? WB : FETCH;
            end
            WB: begin
                bus.rf_we  = 1'b1;
                bus.wb_sel = 2'd1;
                bus.pc_en  = 1'b1;
                state_d    = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
            if (bus.ir_we) ir_q <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: scoreboard bench; each instruction's expected retirement snapshot is checked at its pc_en pulse.
module tb_control_fsm;
    typedef struct packed {
        logic [5:0] alu;
        logic [1:0] b;
        logic       rf;
        logic       ps;
        logic [1:0] wb;
        logic [1:0] src;
        logic       we;
        logic [7:0] cyc;
        logic [3:0] nmem;
        logic [3:0] nir;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int cmps = 0;
    int errs = 0;
    int cnt = 0, nmem = 0, nir = 0, idx = 0;
    exp_t sb[$];
    logic [26:0] outs;

    control_fsm_if #(.WIDTH(16), .ALU_CONT_BITS(6)) bus ();

    control_fsm #(.WIDTH(16), .ALU_CONT_BITS(6)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    assign outs = {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_we, bus.alu_cont, bus.b_sel,
                   bus.ra_addr, bus.rb_addr, bus.rf_we, bus.wb_sel, bus.psr_we, bus.pc_en, bus.pc_src};

    function automatic exp_t mk(input logic [5:0] alu, input logic [1:0] b, input logic rf,
                                input logic ps, input logic [1:0] wb, input logic [1:0] src,
                                input logic we, input int cyc, input int nm);
        mk = '{alu: alu, b: b, rf: rf, ps: ps, wb: wb, src: src, we: we,
               cyc: 8'(cyc), nmem: 4'(nm), nir: 4'd1};
    endfunction

    initial forever begin
        exp_t act, e;
        @(negedge clk);
        #2;
        if (!reset) begin
            cnt = 0; nmem = 0; nir = 0;
        end else begin
            if (cnt != 0 || bus.mem_req) cnt++;
            if (bus.mem_req && bus.addr_sel) nmem++;
            if (bus.ir_we) nir++;
            if (bus.pc_en) begin
                act = '{alu: bus.alu_cont, b: bus.b_sel, rf: bus.rf_we, ps: bus.psr_we,
                        wb: bus.wb_sel, src: bus.pc_src, we: bus.mem_we,
                        cyc: 8'(cnt), nmem: 4'(nmem), nir: 4'(nir)};
                cmps++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_pc_en got %h exp none", act);
                end else begin
                    e = sb.pop_front();
                    if (act !== e) begin
                        errs++;
                        $display("FAIL instr%0d got %h exp %h", idx, act, e);
                    end
                    idx++;
                end
                cnt = 0; nmem = 0; nir = 0;
            end
        end
    end

    task automatic wait_req(input logic b);
        int k = 0;
        while (!(bus.mem_req && bus.addr_sel == b) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k == 20) begin
            cmps++; errs++;
            $display("FAIL req_timeout got mem_req=%b addr_sel=%b exp addr_sel=%b", bus.mem_req, bus.addr_sel, b);
        end
    endtask

    task automatic run(input logic [15:0] ins, input logic [15:0] p, input int fw, input int mw, input exp_t e);
        int k = 0;
        sb.push_back(e);
        bus.psr = p;
        wait_req(1'b0);
        repeat (fw) @(negedge clk);
        bus.mem_rdata = ins;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        if (ins[15:12] == 4'h4 && (ins[7:4] == 4'h0 || ins[7:4] == 4'h4)) begin
            wait_req(1'b1);
            repeat (mw) @(negedge clk);
            bus.mem_ack = 1'b1;
            @(negedge clk);
            bus.mem_ack = 1'b0;
        end
        while (sb.size() != 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            cmps++; errs++;
            $display("FAIL retire_timeout got no pc_en exp instr %h", ins);
            sb.delete();
        end
    endtask

    task automatic chk(input string name, input logic [26:0] got, input logic [26:0] want);
        cmps++;
        if (got !== want) begin
            errs++;
            $display("FAIL %s got %h exp %h", name, got, want);
        end
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        bus.psr = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("reset_outputs", outs, '0);
        reset = 1'b1;
        //   instr     psr      fw mw     alu    b  rf ps wb src we cyc nmem
        run(16'h0354, 16'h0000, 0, 0, mk(6'h05, 0, 1, 1, 0, 0, 0, 3, 0));  // ADD
        run(16'h1280, 16'h0000, 0, 0, mk(6'h01, 2, 1, 0, 0, 0, 0, 3, 0));  // ANDI
        run(16'h5280, 16'h0000, 0, 0, mk(6'h05, 1, 1, 1, 0, 0, 0, 3, 0));  // ADDI
        run(16'h01B2, 16'h0000, 0, 0, mk(6'h0B, 0, 0, 1, 0, 0, 0, 3, 0));  // CMP
        run(16'hB105, 16'h0000, 0, 0, mk(6'h0B, 1, 0, 1, 0, 0, 0, 3, 0));  // CMPI
        run(16'hF1AB, 16'h0000, 0, 0, mk(6'h3F, 2, 1, 0, 0, 0, 0, 3, 0));  // LUI
        run(16'h8142, 16'h0000, 0, 0, mk(6'h07, 0, 1, 0, 0, 0, 0, 3, 0));  // LSH
        run(16'h8103, 16'h0000, 0, 0, mk(6'h07, 1, 1, 0, 0, 0, 0, 3, 0));  // LSHI
        run(16'h0354, 16'h0000, 2, 0, mk(6'h05, 0, 1, 1, 0, 0, 0, 5, 0));  // ADD, fetch wait 2
        run(16'h4102, 16'h0000, 0, 2, mk(6'h00, 0, 1, 0, 1, 0, 0, 7, 3));  // LOAD, mem wait 2
        run(16'h4142, 16'h0000, 0, 0, mk(6'h00, 0, 0, 0, 0, 0, 1, 4, 1));  // STOR
        run(16'hC005, 16'h0040, 0, 0, mk(6'h00, 0, 0, 0, 0, 2, 0, 3, 0));  // BEQ taken
        run(16'hC005, 16'h0000, 0, 0, mk(6'h00, 0, 0, 0, 0, 0, 0, 3, 0));  // BEQ not taken
        run(16'hCF05, 16'hFFFF, 0, 0, mk(6'h00, 0, 0, 0, 0, 0, 0, 3, 0));  // never
        run(16'hCE05, 16'h0000, 0, 0, mk(6'h00, 0, 0, 0, 0, 2, 0, 3, 0));  // always
        run(16'hC605, 16'h0080, 0, 0, mk(6'h00, 0, 0, 0, 0, 2, 0, 3, 0));  // BGT
        run(16'hC405, 16'h0004, 0, 0, mk(6'h00, 0, 0, 0, 0, 2, 0, 3, 0));  // BHI
        run(16'h4E85, 16'h0000, 0, 0, mk(6'h0D, 0, 1, 0, 2, 1, 0, 3, 0));  // JAL
        run(16'h4AC3, 16'h0000, 0, 0, mk(6'h00, 0, 0, 0, 0, 1, 0, 3, 0));  // JLO taken
        run(16'h4DC3, 16'h0000, 0, 0, mk(6'h00, 0, 0, 0, 0, 0, 0, 3, 0));  // JGE not taken
        run(16'h7000, 16'h0000, 0, 0, mk(6'h00, 0, 0, 0, 0, 0, 0, 3, 0));  // undefined op
        run(16'h0000, 16'h0000, 0, 0, mk(6'h00, 0, 0, 0, 0, 0, 0, 3, 0));  // undefined ext
        // reset in FETCH with an ack that must be ignored
        wait_req(1'b0);
        reset = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 16'hFFFF;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        #2;
        chk("rst_fetch_outs", outs, '0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_fetch_resume", outs, {1'b1, 26'b0});
        // reset while a STOR is in MEM
        bus.mem_rdata = 16'h4142;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        wait_req(1'b1);
        chk("stor_in_mem", {outs[26:24], 1'b0, outs[22:0]}, {3'b111, 1'b0, 6'h00, 2'd0, 4'h1, 4'h2, 7'b0});
        reset = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_mem_outs", outs, '0);
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_mem_resume", outs, {1'b1, 26'b0});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish exp finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/control_fsm.md
# control_fsm

Multicycle control unit for the 16-bit datapath: it fetches instructions over a req/ack memory port, decodes them and drives the ALU control code, operand selects, register-file and PSR write enables, and PC update. It is the producer side of the 6-bit ALU control interface and the consumer of the ALU's 16-bit PSR flag word. It sits between instruction memory, the register file/ALU and the PC register.

## Interface
- WIDTH, 16, instruction/data width
- ALU_CONT_BITS, 6, ALU control code width
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- mem_rdata  in  WIDTH  memory read data (instruction in FETCH, data in MEM)
- mem_ack  in  1  memory completes the current access on a rising edge where mem_req=1
- psr  in  WIDTH  latched flags: C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7
- mem_req  out  1  memory access request, held until ack
- mem_we  out  1  write strobe (STOR), valid with mem_req
- addr_sel  out  1  0: address=PC, 1: address=reg B (Raddr)
- ir_we  out  1  load instruction register
- alu_cont  out  ALU_CONT_BITS  ALU operation code
- b_sel  out  2  0: reg B, 1: imm8 sign-extended, 2: imm8 zero-extended
- ra_addr, rb_addr  out  4  register read addresses (Rdest, Rsrc)
- rf_we  out  1  register write enable; write address is ra_addr
- wb_sel  out  2  0: ALU, 1: mem_rdata, 2: PC+1
- psr_we  out  1  latch ALU flags into PSR
- pc_en  out  1  update PC; pc_src 0: PC+1, 1: ALU result, 2: PC+sign-extended disp8
- pc_src  out  2  see pc_en

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Reset -> FETCH.
- FETCH: mem_req=1, addr_sel=0, mem_we=0. On mem_ack: ir_we=1, next DECODE. No ack: stay.
- DECODE: register reads settle; IR fields: op=[15:12], rd=[11:8], ext=[7:4], rs=[3:0], imm8=[7:0]. Next EXEC.
- EXEC, op 0000 R-type by ext: AND 0001/OR 0010/XOR 0011/ADD 0101/ADDU 0110/SUB 1001/CMP 1011/MOV 1101; alu_cont = {2'b00, ext}; b_sel=0.
- EXEC, immediate ops: op in {0001,0010,0011,0101,0110,1001,1011,1101}; alu_cont={2'b00,op}; b_sel=1 except ANDI/ORI/XORI (b_sel=2).
- LUI op 1111: alu_cont=111111, b_sel=2. Shift op 1000: LSH ext 0100 (b_sel=0), LSHI ext 000x (b_sel=1); alu_cont=000111.
- rf_we=1 in EXEC for all above except CMP/CMPI. psr_we=1 only for ADD, ADDI, SUB, SUBI, CMP, CMPI.
- Non-memory EXEC: pc_en=1, pc_src=0, next FETCH.
- op 0100: LOAD ext 0000 / STOR ext 0100 -> MEM. JAL ext 1000: rf_we=1, wb_sel=2, alu_cont=001101 (pass b=Rsrc), pc_en=1, pc_src=1 -> FETCH. Jcond ext 1100: cond=rd; if taken pc_src=1 else 0; pc_en=1 -> FETCH.
- Bcond op 1100: cond=rd; taken -> pc_src=2, else 0; pc_en=1 -> FETCH.
- Conditions: EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; HI 0100 L; LS 0101 !L; GT 0110 N; LE 0111 !N; FS 1000 F; FC 1001 !F; LO 1010 !L&!Z; HS 1011 L|Z; LT 1100 !N&!Z; GE 1101 N|Z; UC 1110 1; 1111 never.
- MEM: mem_req=1, addr_sel=1, mem_we=1 for STOR. On ack: LOAD -> WB; STOR -> pc_en=1, pc_src=0, FETCH.
- WB: rf_we=1, wb_sel=1 (mem_rdata captured same cycle as ack is registered into WB), pc_en=1, pc_src=0 -> FETCH.
- Undefined op/ext: NOP — no rf_we/psr_we, pc_en=1 pc_src=0.

## Timing
- All outputs are decoded from registered state + IR; default 0 in every state. Reset (reset=0 at edge) -> FETCH, IR=0, all outputs 0, alu_cont=000000; applies mid-access: outstanding mem_req drops next cycle, ack ignored.
- Zero-wait memory (ack on first req cycle): ALU/branch = 3 cycles, STOR = 4, LOAD = 5. Each wait cycle adds one.
- mem_req/addr_sel/mem_we stable from first req cycle to ack cycle inclusive; deasserted the cycle after ack.
- ir_we, rf_we, psr_we, pc_en are single-cycle pulses; exactly one pc_en per instruction.
- Condition evaluated on psr value in EXEC; psr_we of the preceding CMP has taken effect by then.

## Test plan
- ADD R3,R4 (0x0354), ack immediate -> ir_we cycle1, EXEC cycle3: alu_cont=000101, b_sel=0, rf_we=1, psr_we=1, pc_en=1 pc_src=0.
- ANDI R2,0x80 (0x1280) -> b_sel=2, alu_cont=000001, psr_we=0; ADDI R2,0x80 -> b_sel=1, psr_we=1.
- LOAD R1,[R2] (0x4102), ack delayed 2 cycles in MEM -> mem_req held 3 cycles with addr_sel=1, then WB: rf_we=1, wb_sel=1; total 7 cycles.
- BEQ with psr=0x0040 -> pc_src=2; psr=0x0000 -> pc_src=0; cond 1111 never taken, 1110 always.
- JAL R14,R5 (0x4E85) -> rf_we=1, wb_sel=2, pc_src=1, alu_cont=001101.
- reset=0 during FETCH with mem_req=1 and during MEM of STOR -> next cycle state FETCH, all outputs 0, no mem_we, no pc_en.
